// File: rtl/sad8_controller.sv
// Sum-of-absolute-differences sequencer around the AbsDiff8 datapath.
// Latches one operand pair at a time, waits for settling, then accumulates.
module AbsDiff8_circuit (
  input  logic [7:0] reff,
  input  logic [7:0] data,
  output logic [7:0] diff
);

  logic [8:0] w_sub;

  assign w_sub = {1'b0, reff} - {1'b0, data};
  // Borrow out means data > reff: negate the low byte.
  assign diff  = w_sub[8] ? (~w_sub[7:0] + 8'd1) : w_sub[7:0];

endmodule

module sad8_controller #(
  parameter int N_PAIRS       = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int ACC_W         = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_reff,
  input  logic [7:0]       in_data,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sad
);

  localparam int CW = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_PAIR   = CW'(N_PAIRS - 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GET,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_reff;
  logic [7:0]       r_data;
  logic [ACC_W-1:0] r_sad;
  logic [CW-1:0]    r_pairs;
  logic [SW-1:0]    r_settle;
  logic [7:0]       w_diff;
  logic             w_settled;

  AbsDiff8_circuit u_absdiff (
    .reff (r_reff),
    .data (r_data),
    .diff (w_diff)
  );

  assign w_settled = (r_settle == '0);

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_GET;
      end
      S_GET: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_settled)
          w_next = (r_pairs == LAST_PAIR) ? S_DONE : S_GET;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_reff   <= '0;
      r_data   <= '0;
      r_sad    <= '0;
      r_pairs  <= '0;
      r_settle <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sad   <= '0;
            r_pairs <= '0;
          end
        end
        S_GET: begin
          if (in_valid) begin
            r_reff   <= in_reff;
            r_data   <= in_data;
            r_settle <= SETTLE_LOAD;
          end
        end
        // diff is only trusted once the settle budget has run out.
        S_WAIT: begin
          if (w_settled) begin
            r_sad   <= r_sad + ACC_W'(w_diff);
            r_pairs <= r_pairs + CW'(1);
          end else begin
            r_settle <= r_settle - SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sad = r_sad;

endmodule

// File: tb/tb_sad8_controller.sv
// Directed and random checks for sad8_controller.
// Cycle n is the clock period following edge n-1; start is sampled at edge 0.
module tb_sad8_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_reff = '0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [9:0] sad;

  logic        b_start = 1'b0;
  logic        b_in_valid = 1'b0;
  logic [7:0]  b_reff = '0;
  logic [7:0]  b_data = '0;
  logic        b_in_ready;
  logic        b_busy;
  logic        b_done;
  logic [11:0] b_sad;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sad8_controller #(
    .N_PAIRS(4), .SETTLE_CYCLES(2), .ACC_W(10)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reff(in_reff), .in_data(in_data),
    .busy(busy), .done(done), .sad(sad)
  );

  sad8_controller dut_def (
    .clk(clk), .rst(rst), .start(b_start),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_reff(b_reff), .in_data(b_data),
    .busy(b_busy), .done(b_done), .sad(b_sad)
  );

  typedef struct {
    string            name;
    logic [3:0][7:0]  r;
    logic [3:0][7:0]  d;
    logic [3:0][3:0]  g;
    bit               noisy;
    int               exp_sad;
    int               exp_done;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_burst(
    input  logic [3:0][7:0] r,
    input  logic [3:0][7:0] d,
    input  logic [3:0][3:0] g,
    input  bit              noisy,
    output int              dcyc,
    output int              ndone,
    output int              s,
    output int              idle_cyc,
    output int              rdy_cyc
  );
    int k;
    int gc;
    k = 0;
    gc = int'(g[0]);
    dcyc = -1;
    ndone = 0;
    s = -1;
    idle_cyc = -1;
    rdy_cyc = 0;
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c < 300 && idle_cyc < 0; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (done) begin
        ndone++;
        dcyc = c;
        s = int'(sad);
      end
      if (in_ready) rdy_cyc++;
      if (!busy) begin
        idle_cyc = c;
        start = 1'b0;
        in_valid = 1'b0;
      end else if (in_ready && k < 4) begin
        start = 1'b0;
        if (gc > 0) begin
          in_valid = 1'b0;
          gc--;
        end else begin
          in_valid = 1'b1;
          in_reff = r[k];
          in_data = d[k];
          k++;
          gc = (k < 4) ? int'(g[k]) : 0;
        end
      end else if (noisy) begin
        start = 1'b1;
        in_valid = 1'($urandom_range(1));
        in_reff = 8'($urandom_range(255));
        in_data = 8'($urandom_range(255));
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic check_quiet(input string nm);
    int bad;
    bad = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (busy || done) bad++;
    end
    chk(nm, bad, 0);
  endtask

  vec_t vt[5];

  initial begin
    int dcyc, ndone, s, idle_cyc, rdy;
    int gsum, esad, cyc, nd;
    logic [3:0][7:0] rr, dd;
    logic [3:0][3:0] gg;

    vt[0] = '{"case1", {8'd128, 8'd0, 8'd3, 8'd10},
              {8'd128, 8'd255, 8'd10, 8'd3}, '0, 1'b0, 269, 13};
    vt[1] = '{"gaps", {8'd128, 8'd0, 8'd3, 8'd10},
              {8'd128, 8'd255, 8'd10, 8'd3},
              {4'd3, 4'd0, 4'd3, 4'd0}, 1'b0, 269, 19};
    vt[2] = '{"noisy", {8'd128, 8'd0, 8'd3, 8'd10},
              {8'd128, 8'd255, 8'd10, 8'd3}, '0, 1'b1, 269, 13};
    vt[3] = '{"zeros", '0, '0, '0, 1'b0, 0, 13};
    vt[4] = '{"mixed", {8'd77, 8'd1, 8'd200, 8'd5},
              {8'd78, 8'd0, 8'd100, 8'd9},
              {4'd0, 4'd2, 4'd0, 4'd1}, 1'b0, 106, 16};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sad", int'(sad), 0);
    chk("rst_def_sad", int'(b_sad), 0);
    chk("rst_def_busy", int'(b_busy), 0);
    rst = 1'b0;

    foreach (vt[i]) begin
      gsum = 0;
      for (int j = 0; j < 4; j++) gsum += int'(vt[i].g[j]);
      run_burst(vt[i].r, vt[i].d, vt[i].g, vt[i].noisy,
                dcyc, ndone, s, idle_cyc, rdy);
      chk({vt[i].name, "_sad"}, s, vt[i].exp_sad);
      chk({vt[i].name, "_done_cyc"}, dcyc, vt[i].exp_done);
      chk({vt[i].name, "_ndone"}, ndone, 1);
      chk({vt[i].name, "_idle_cyc"}, idle_cyc, vt[i].exp_done + 1);
      chk({vt[i].name, "_ready_cyc"}, rdy, 4 + gsum);
      chk({vt[i].name, "_sad_hold"}, int'(sad), vt[i].exp_sad);
      check_quiet({vt[i].name, "_quiet"});
    end

    // Reset in the WAIT of pair 2 abandons the burst.
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b1;
    in_reff = 8'd10;
    in_data = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    in_reff = 8'd3;
    in_data = 8'd10;
    @(posedge clk);
    #1;
    chk("mid_wait_busy", int'(busy & ~in_ready), 1);
    chk("mid_sad_pair1", int'(sad), 7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_ready", int'(in_ready), 0);
    chk("rst_mid_sad", int'(sad), 0);
    check_quiet("rst_mid_quiet");
    run_burst({4{8'd1}}, {4{8'd2}}, '0, 1'b0,
              dcyc, ndone, s, idle_cyc, rdy);
    chk("post_rst_sad", s, 4);
    chk("post_rst_done_cyc", dcyc, 13);

    // Default parameters, all (255,0).
    @(negedge clk);
    b_start = 1'b1;
    b_in_valid = 1'b1;
    b_reff = 8'd255;
    b_data = 8'd0;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    cyc = 1;
    dcyc = -1;
    nd = 0;
    s = -1;
    while (cyc < 200 && (nd == 0 || b_busy)) begin
      if (b_done) begin
        nd++;
        dcyc = cyc;
        s = int'(b_sad);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    b_in_valid = 1'b0;
    chk("def_sad", s, 4080);
    chk("def_done_cyc", dcyc, 81);
    chk("def_ndone", nd, 1);

    // Random bursts against a |reff-data| model.
    for (int n = 0; n < 100; n++) begin
      esad = 0;
      gsum = 0;
      for (int j = 0; j < 4; j++) begin
        rr[j] = 8'($urandom_range(255));
        dd[j] = 8'($urandom_range(255));
        gg[j] = 4'($urandom_range(2));
        gsum += int'(gg[j]);
        esad += (rr[j] > dd[j]) ? int'(rr[j]) - int'(dd[j])
                                : int'(dd[j]) - int'(rr[j]);
      end
      run_burst(rr, dd, gg, n[0], dcyc, ndone, s, idle_cyc, rdy);
      chk($sformatf("rand%0d_sad", n), s, esad);
      chk($sformatf("rand%0d_done_cyc", n), dcyc, 13 + gsum);
      chk($sformatf("rand%0d_ndone", n), ndone, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
